// File: rtl/pong_disp_pkg.sv
// Shared display constants for the Pong board: digit count, dark values and hex segment table.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package pong_disp_pkg;

    localparam int                    NUM_DIGITS  = 8;
    localparam logic [6:0]            SEG_OFF     = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] ENABLE_NONE = 8'hFF;

    // Entry order in the literal is F down to 0, so SEG_TABLE[h] is the pattern for hex h.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Bit i set when digits 7..i are all zero; digit 0 is never blanked.
    function automatic logic [NUM_DIGITS-1:0] lzb_mask(input logic [4*NUM_DIGITS-1:0] digits);
        logic [NUM_DIGITS-1:0] m;
        logic                  all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS-1; i >= 1; i--) begin
            all_zero = all_zero && (digits[4*i +: 4] == 4'h0);
            m[i]     = all_zero;
        end
        return m;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder, shared with the score path.
module hex_to_seg7
    import pong_disp_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_TABLE[hex_i];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Scans eight buffered hex digits onto a multiplexed 7-seg display; new digits take effect at frame start.
// Define SEG7_LZB_EN to additionally blank leading zero digits.
module seg7_scan_driver
    import pong_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
)
(
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              out,
    output logic [NUM_DIGITS-1:0]   en_out,
    output logic                    frame_done
);

    localparam int            PW   = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [2:0]              idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [6:0]              out_q, out_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic                    fd_q, fd_d;

    logic                    tick;
    logic                    boundary;
    logic [2:0]              next_idx;
    logic [3:0]              nxt_digit;
    logic [6:0]              nxt_seg;
    logic [NUM_DIGITS-1:0]   blank_vec;

    assign tick     = (presc_q == LAST);
    assign next_idx = idx_q + 3'd1;
    assign boundary = tick && (idx_q == 3'd7);

    hex_to_seg7 u_dec (
        .hex_i (nxt_digit),
        .seg_o (nxt_seg)
    );

    always_comb begin
        presc_d    = tick ? '0 : presc_q + PW'(1);
        idx_d      = tick ? next_idx : idx_q;
        active_d   = active_q;
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;

        // A load coinciding with the frame boundary bypasses the pending buffer.
        if (boundary) begin
            if (load) begin
                active_d = digits_in;
            end else if (pend_vld_q) begin
                active_d = pending_q;
            end
            pend_vld_d = 1'b0;
        end else if (load) begin
            pending_d  = digits_in;
            pend_vld_d = 1'b1;
        end

        // Decode from active_d so digit 0 of a new frame already sees the swapped buffer.
        nxt_digit = active_d[{next_idx, 2'b00} +: 4];
`ifdef SEG7_LZB_EN
        blank_vec = blank_mask | lzb_mask(active_d);
`else
        blank_vec = blank_mask;
`endif

        out_d = out_q;
        en_d  = en_q;
        if (tick) begin
            if (blank_vec[next_idx]) begin
                out_d = SEG_OFF;
                en_d  = ENABLE_NONE;
            end else begin
                out_d = nxt_seg;
                en_d  = ~(8'b0000_0001 << next_idx);
            end
        end
        fd_d = boundary;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            presc_q    <= '0;
            idx_q      <= 3'd7;
            active_q   <= '0;
            pending_q  <= '0;
            pend_vld_q <= 1'b0;
            out_q      <= SEG_OFF;
            en_q       <= ENABLE_NONE;
            fd_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            out_q      <= out_d;
            en_q       <= en_d;
            fd_q       <= fd_d;
        end
    end

    assign out        = out_q;
    assign en_out     = en_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with REFRESH_DIV=4: slot/frame arithmetic model plus directed literal checks.
module tb_seg7_scan_driver;

    localparam int DIV = 4;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] digits_in = '0;
    logic        load = 1'b0;
    logic [7:0]  blank_mask = '0;
    logic [6:0]  out;
    logic [7:0]  en_out;
    logic        frame_done;

    int checks = 0;
    int failures = 0;
    int printed = 0;

    seg7_scan_driver #(.REFRESH_DIV(DIV)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .digits_in  (digits_in),
        .load       (load),
        .blank_mask (blank_mask),
        .out        (out),
        .en_out     (en_out),
        .frame_done (frame_done)
    );

    always #5 Clk = ~Clk;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [7:0] en_seq [8]   = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [6:0] scan_seq [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    logic [7:0] lzb_en [8]   = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [6:0] lzb_out [8]  = '{7'h12, 7'h40, 7'h30, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    // Model: cycles since reset release define slot and digit; a frame shows the newest load up to its first edge.
    int          m_cyc = 0;
    logic [31:0] m_latest = '0;
    logic [31:0] m_shown = '0;
    logic [7:0]  m_en = 8'hFF;
    logic [6:0]  m_out = 7'h7F;

    initial begin
        int  d;
        logic lz;
        forever begin
            @(posedge Clk or posedge Rst);
            if (Rst) begin
                m_cyc = 0; m_latest = '0; m_shown = '0; m_en = 8'hFF; m_out = 7'h7F;
            end else begin
                if (load) m_latest = digits_in;
                if (m_cyc % DIV == DIV - 1) begin
                    d = ((m_cyc + 1) / DIV - 1) % 8;
                    if (d == 0) m_shown = m_latest;
                    lz = 1'b0;
`ifdef SEG7_LZB_EN
                    lz = (d >= 1) && ((m_shown >> (4 * d)) == 32'h0);
`endif
                    if (blank_mask[d] || lz) begin
                        m_en = 8'hFF; m_out = 7'h7F;
                    end else begin
                        m_en = ~(8'h01 << d); m_out = seg_tab[m_shown[4*d +: 4]];
                    end
                end
                m_cyc = m_cyc + 1;
            end
        end
    end

    initial begin
        logic exp_fd;
        forever begin
            @(negedge Clk);
            exp_fd = (m_cyc >= DIV) && (m_cyc % DIV == 0) && ((m_cyc / DIV - 1) % 8 == 0);
            checks++;
            if (en_out !== m_en || out !== m_out || frame_done !== exp_fd) begin
                failures++;
                if (printed < 20) begin
                    printed++;
                    $display("FAIL model t=%0t: en_out=%h out=%h frame_done=%b, required en_out=%h out=%h frame_done=%b",
                             $time, en_out, out, frame_done, m_en, m_out, exp_fd);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] ee, input logic [6:0] eo);
        checks++;
        if (en_out !== ee || out !== eo) begin
            failures++;
            $display("FAIL %s: en_out=%h out=%h, required en_out=%h out=%h", nm, en_out, out, ee, eo);
        end
    endtask

    task automatic chk_fd(input string nm, input logic efd);
        checks++;
        if (frame_done !== efd) begin
            failures++;
            $display("FAIL %s: frame_done=%b, required %b", nm, frame_done, efd);
        end
    endtask

    task automatic wait_fd(input string nm);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge Clk);
            if (frame_done === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s: frame_done not seen within 200 cycles, required a pulse", nm);
        end
    endtask

    task automatic pulse_load(input logic [31:0] v);
        digits_in = v;
        load = 1'b1;
        @(negedge Clk);
        load = 1'b0;
    endtask

    initial begin
        // Reset: dark during reset and for the first DIV cycles after release.
        repeat (2) begin
            @(negedge Clk);
            chk("reset_hold", 8'hFF, 7'h7F);
            chk_fd("reset_hold_fd", 1'b0);
        end
        @(negedge Clk);
        Rst = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            chk("post_reset_dark", 8'hFF, 7'h7F);
            chk_fd("post_reset_fd", 1'b0);
        end
        @(negedge Clk);
        chk("first_tick_digit0", 8'hFE, 7'h40);
        chk_fd("first_frame_done", 1'b1);

        // Scan order: mid-frame load appears only from the next frame.
        repeat (8) @(negedge Clk);
        pulse_load(32'h76543210);
        wait_fd("scan_fd");
        chk("scan_d0", en_seq[0], scan_seq[0]);
        for (int j = 1; j < 8; j++) begin
            repeat (4) @(negedge Clk);
            chk("scan_dj", en_seq[j], scan_seq[j]);
        end

        // Boundary load: digits_in lands at the same edge as the wrap.
        repeat (3) @(negedge Clk);
        pulse_load(32'h000000AB);
        chk("boundary_d0_B", 8'hFE, 7'h03);
        chk_fd("boundary_fd", 1'b1);
        repeat (4) @(negedge Clk);
        chk("boundary_d1_A", 8'hFD, 7'h08);

        // Double load within one frame: last one wins.
        repeat (4) @(negedge Clk);
        pulse_load(32'h11111111);
        repeat (4) @(negedge Clk);
        pulse_load(32'h22222222);
        wait_fd("double_fd");
        for (int j = 0; j < 8; j++) begin
            if (j > 0) repeat (4) @(negedge Clk);
            chk("double_load", en_seq[j], 7'h24);
        end

        // Blank mask darkens digits 0..3.
        blank_mask = 8'h0F;
        wait_fd("blank_fd");
        for (int j = 0; j < 8; j++) begin
            if (j > 0) repeat (4) @(negedge Clk);
            if (j < 4) chk("blank_dark", 8'hFF, 7'h7F);
            else       chk("blank_lit", en_seq[j], 7'h24);
        end
        blank_mask = 8'h00;

`ifdef SEG7_LZB_EN
        pulse_load(32'h00000305);
        wait_fd("lzb_fd");
        for (int j = 0; j < 8; j++) begin
            if (j > 0) repeat (4) @(negedge Clk);
            chk("lzb", lzb_en[j], lzb_out[j]);
        end
`endif

        // Reset mid-frame with a pending load: pending data is discarded.
        wait_fd("pre_rst_fd");
        repeat (4) @(negedge Clk);
        pulse_load(32'hDEADBEEF);
        repeat (15) @(negedge Clk);
        @(negedge Clk);
        #2 Rst = 1'b1;
        #1 chk("rst_mid_immediate", 8'hFF, 7'h7F);
        chk_fd("rst_mid_fd", 1'b0);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        wait_fd("post_rst_fd");
        chk("post_rst_d0", 8'hFE, 7'h40);
`ifndef SEG7_LZB_EN
        repeat (4) @(negedge Clk);
        chk("post_rst_d1", 8'hFD, 7'h40);
`endif
        repeat (40) @(negedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Drives the board's 8-digit multiplexed seven-segment display through the shared segment bus `out` and the digit-enable bus `en_out`.
- Sits between the Pong score/lights logic and the display pins.
- Accepts eight 4-bit hex digits through a load strobe and buffers them.
- Applies new digits only at a frame boundary, so the display never shows a mixed frame.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot. Minimum 2. At 100 MHz this gives 1 kHz per digit and 125 Hz per frame.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  asynchronous active-high reset.
- digits_in  in  32  digit i = digits_in[4i+3:4i]; digit 0 is rightmost.
- load  in  1  1-cycle strobe; captures digits_in into the pending buffer.
- blank_mask  in  8  bit i=1 forces digit i dark; sampled on every slot tick.
- out  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- en_out  out  8  digit enables, active-low, one-cold, registered.
- frame_done  out  1  1-cycle pulse when the scan wraps from digit 7 to digit 0.

Behaviour:
- Reset values (asynchronous):
  - prescaler = 0
  - idx = 7
  - active = 32'h0, pending = 32'h0, pend_valid = 0
  - out = 7'h7F, en_out = 8'hFF, frame_done = 0
- Prescaler counts 0..REFRESH_DIV-1. `tick` is asserted in the cycle where the count equals REFRESH_DIV-1; the count then returns to 0.
- On each tick:
  - idx <= (idx+1) mod 8.
  - At the same edge, en_out <= ~(8'b1 << next_idx) and out <= seg(digit[next_idx]).
  - If blank_mask[next_idx]=1, en_out <= 8'hFF and out <= 7'h7F.
- Between ticks, all outputs hold their values.
- After Rst deasserts, the display is dark for exactly REFRESH_DIV cycles. The first tick selects digit 0.
- Frame boundary: a tick where idx==7.
  - frame_done = 1 for that one cycle.
  - If pend_valid, then active <= pending and pend_valid <= 0. Digit 0 of the new frame uses the new value at that same edge.
- load handling:
  - Sets pending <= digits_in and pend_valid <= 1.
  - Multiple loads within one frame: the last one wins.
  - load in the same cycle as a boundary tick: digits_in goes directly to active and is used for digit 0 at that edge; pend_valid <= 0.
- Segment decode, hex 0..F, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, B=03, C=46, D=21, E=06, F=0E
- Rst asserted mid-frame: everything returns to reset values immediately, and any pending data is discarded.

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- Defined:
  - Digit i (i ≥ 1) is blanked if active digits 7..i are all 0.
  - Digit 0 is never blanked by this rule.
  - The result is ORed with blank_mask.
  - Example: active = 32'h00000305 shows "305" on digits 2..0; digits 7..3 are dark (en_out bit = 1).
- Not defined: only blank_mask controls blanking.

Decomposition:
- Shared package (pong_disp_pkg):
  - NUM_DIGITS=8
  - SEG_OFF=7'h7F
  - ENABLE_NONE=8'hFF
  - the 16-entry hex segment constant table
- Sub-module hex_to_seg7: combinational 4-bit to 7-bit active-low decoder. It is shared with the score display path and instantiated once here on digit[next_idx].
- Prescaler, index counter, and buffers stay in seg7_scan_driver.

Test Plan (REFRESH_DIV=4, 10 ns clock):
- Reset check:
  - Stimulus: Rst=1 for 30 ns, then release.
  - Required: out=7F, en_out=FF, frame_done=0 during reset and for 4 cycles after.
  - Then en_out=FE and out=40 (active=0).
- Scan order:
  - Stimulus: load digits_in=32'h76543210 mid-frame.
  - Required: the current frame still shows 0s.
  - Required after the next frame_done: en_out steps FE,FD,FB,...,7F every 4 cycles, with out=40,79,24,30,19,12,02,78.
- Boundary load:
  - Stimulus: load=1 coincident with the idx==7 tick, digits_in=32'h000000AB.
  - Required: at the same edge, en_out=FE and out=03 (B); next slot out=08 (A).
- Double load:
  - Stimulus: load 32'h11111111 then 32'h22222222 in the same frame.
  - Required: the next frame shows 24 on every digit; 79 never appears.
- Blanking:
  - Stimulus: blank_mask=8'h0F.
  - Required: digits 0..3 slots give en_out=FF and out=7F; digits 4..7 scan normally.
  - With SEG7_LZB_EN and active=32'h00000305: digits 3..7 are dark and digit 1 shows 40.
- Reset mid-frame:
  - Stimulus: Rst pulse during the digit 5 slot with a load pending.
  - Required: out=7F and en_out=FF immediately.
  - Required: the first frame after release shows 0s, i.e. the pending data is discarded.
